// File: rtl/roll_sequencer.sv
// Dice-roll sequencer: decelerating spin that reloads two dice from a free-running LFSR,
// then latches the final values and pulses done for the game controller.
module roll_sequencer #(
  parameter int TICK_DIV   = 500000,
  parameter int SPIN_STEPS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       busy_o,
  output logic       step_o,
  output logic       done_o,
  output logic [2:0] die_a,
  output logic [2:0] die_b,
  output logic [3:0] sum_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [3:0]    STEPS_LAST = 4'(SPIN_STEPS);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

  state_t         state;
  logic [15:0]    lfsr;
  logic [TW-1:0]  tick_cnt;
  logic [3:0]     wait_cnt;
  logic [3:0]     interval;
  logic [3:0]     step_cnt;

  logic [15:0]    lfsr_next;
  logic [7:0]     mod_a;
  logic [7:0]     mod_b;
  logic [2:0]     die_a_next;
  logic [2:0]     die_b_next;
  logic [3:0]     sum_next;
  logic           tick;
  logic           step;
  logic [3:0]     step_cnt_next;

  // Galois form of x^16+x^14+x^13+x^11+1
  always_comb begin
    lfsr_next     = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    mod_a         = lfsr[7:0] % 8'd6;
    mod_b         = lfsr[15:8] % 8'd6;
    die_a_next    = 3'(mod_a) + 3'd1;
    die_b_next    = 3'(mod_b) + 3'd1;
    sum_next      = {1'b0, die_a_next} + {1'b0, die_b_next};
    tick          = (tick_cnt == TICK_LAST);
    step          = tick && (wait_cnt == (interval - 4'd1));
    step_cnt_next = step_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      tick_cnt <= '0;
      wait_cnt <= '0;
      interval <= '0;
      step_cnt <= '0;
      busy_o   <= 1'b0;
      step_o   <= 1'b0;
      done_o   <= 1'b0;
      die_a    <= 3'd1;
      die_b    <= 3'd1;
      sum_o    <= 4'd2;
    end else begin
      lfsr   <= lfsr_next;
      step_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= SPIN;
            busy_o   <= 1'b1;
            tick_cnt <= '0;
            wait_cnt <= '0;
            interval <= 4'd1;
            step_cnt <= '0;
          end
        end
        SPIN: begin
          tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
          if (step) begin
            die_a    <= die_a_next;
            die_b    <= die_b_next;
            sum_o    <= sum_next;
            step_o   <= 1'b1;
            wait_cnt <= '0;
            step_cnt <= step_cnt_next;
            // interval is not advanced on the final step so it cannot wrap at SPIN_STEPS=15
            if (step_cnt_next == STEPS_LAST) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              interval <= interval + 4'd1;
            end
          end else if (tick) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/roll_sequencer.md
Name: roll_sequencer

Overview:
- Sequences the dice-roll datapath for the game controller.
- On a one-cycle start pulse from the controller, it runs a decelerating spin: the dice are re-loaded from a free-running LFSR at progressively longer intervals.
- It then latches the final values and returns a one-cycle done pulse, which the controller uses as its ROLL-finished input.
- It also drives the dice display update strobe.

Parameters:
- TICK_DIV, 500000, clk cycles per spin tick; legal range ≥1; the value 1 means every cycle is a tick.
- SPIN_STEPS, 12, number of dice re-loads per roll; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle roll request; accepted only in IDLE.
- busy_o  output  1  high while in SPIN.
- step_o  output  1  one-cycle strobe, coincident with every new dice value.
- done_o  output  1  one-cycle pulse; final dice are valid.
- die_a  output  3  current die A value, 1..6.
- die_b  output  3  current die B value, 1..6.
- sum_o  output  4  die_a + die_b, 2..12, registered with the dice.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - die_a=1, die_b=1, sum_o=2.
  - busy_o=0, step_o=0, done_o=0.
  - LFSR reloads 16'hACE1; tick_cnt, wait_cnt, interval and step_cnt clear.
  - Reset mid-SPIN aborts the roll; no done_o is produced.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle in all states except during reset, so the outcome depends on the press timing.
  - Nonzero seed; lockup is impossible.
- FSM states: IDLE, SPIN, DONE.
  - IDLE: when start_i=1, go to SPIN next cycle. Clear tick_cnt=0, wait_cnt=0, interval=1, step_cnt=0.
  - SPIN: busy_o=1.
    - tick_cnt counts 0..TICK_DIV-1 and wraps. A tick is the cycle in which tick_cnt==TICK_DIV-1.
    - On a tick: if wait_cnt==interval-1, a step occurs; otherwise wait_cnt increments.
    - On a step:
      - die_a <= (lfsr[7:0] mod 6)+1.
      - die_b <= (lfsr[15:8] mod 6)+1.
      - sum_o <= new die_a + new die_b, computed from the same LFSR sample.
      - step_o=1 the next cycle.
      - wait_cnt <= 0; interval <= interval+1; step_cnt <= step_cnt+1.
    - The step at which step_cnt reaches SPIN_STEPS moves the state to DONE.
    - Spin cost: step k occurs at tick k(k+1)/2. The last step occurs at tick SPIN_STEPS(SPIN_STEPS+1)/2.
  - DONE: lasts one cycle.
    - done_o=1, busy_o=0, step_o=1 (last step strobe); go to IDLE unconditionally.
- Latency: with start sampled at cycle 0, SPIN is entered at cycle 1. With N = SPIN_STEPS(SPIN_STEPS+1)/2:
  - Final dice are visible and done_o=1 at cycle 1 + TICK_DIV·N.
  - IDLE resumes the next cycle.
- start_i in SPIN or DONE is ignored; there is no queuing. start_i held high for many cycles starts exactly one roll per IDLE visit.
- Dice hold their last rolled values in IDLE until the next step or reset.
- Widths: interval and wait_cnt are 4 bits, step_cnt is 4 bits, tick_cnt is ceil(log2(TICK_DIV)) bits with a minimum of 1. No counter may overflow within the legal parameter range.

Test Plan:
1. Reset with TICK_DIV=2, SPIN_STEPS=3 → die_a=1, die_b=1, sum_o=2, busy_o=0, done_o=0, step_o=0.
2. start_i one cycle at cycle 0, TICK_DIV=2, SPIN_STEPS=3:
   - busy_o=1 for cycles 1..12.
   - step_o high exactly at cycles 3, 7 and 13.
   - done_o high only at cycle 13; busy_o=0 from cycle 13.
3. Any roll against a reference LFSR model → every step gives die_a=(lfsr[7:0]%6)+1, die_b=(lfsr[15:8]%6)+1 and sum_o=die_a+die_b. Over 1000 rolls all dice are in 1..6 and all sums are in 2..12.
4. start_i pulsed during SPIN and again in the DONE cycle → no extra step_o, no second done_o, and the cycle timing is identical to scenario 2.
5. rst asserted at cycle 5 mid-SPIN → the next cycle shows IDLE, dice at 1/1, sum_o=2, and no done_o. A fresh start then produces the full 13-cycle sequence.
6. TICK_DIV=1, SPIN_STEPS=1, start held high for 10 cycles → done_o pulses at cycle 2, then again 2 cycles after each IDLE re-entry; busy_o never overlaps done_o.
